// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard.
// - Register 0 reads as zero and ignores writes and issues.
// - Indices at or above NREGS read as zero and ignore writes and issues.
// - Reads, bypass and busy lookups are combinational.
// - busy_count is derived from stored state only.
module regfile_sb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            write_enable,
   input  logic [AW-1:0]   write_addr,
   input  logic [XLEN-1:0] write_data,
   input  logic [AW-1:0]   read_addr_1,
   input  logic [AW-1:0]   read_addr_2,
   output logic [XLEN-1:0] read_data_1,
   output logic [XLEN-1:0] read_data_2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_addr,
   output logic            busy_1,
   output logic            busy_2,
   output logic [AW:0]     busy_count
);

   // One extra bit so the compare also covers NREGS equal to 2**AW.
   localparam logic [AW:0] RegLimit = (AW+1)'(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   logic wr_hit;
   logic iss_hit;
   logic rd_live_1;
   logic rd_live_2;
   logic bypass_1;
   logic bypass_2;

   // An index is live when it names a real, writable register.
   function automatic logic addr_live(input logic [AW-1:0] addr);
      return (addr != '0) && ({1'b0, addr} < RegLimit);
   endfunction

   // Qualify the write and issue strobes against the live index range.
   always_comb begin
      wr_hit    = write_enable & addr_live(write_addr);
      iss_hit   = issue_valid  & addr_live(issue_addr);
      rd_live_1 = addr_live(read_addr_1);
      rd_live_2 = addr_live(read_addr_2);
      // wr_hit implies a live write index, so equality implies a live read index.
      bypass_1  = wr_hit && (write_addr == read_addr_1);
      bypass_2  = wr_hit && (write_addr == read_addr_2);
   end

   // Read port 1: zero for dead indices, writeback bypass, else stored value.
   always_comb begin
      read_data_1 = '0;
      busy_1      = 1'b0;
      if (rd_live_1) begin
         if (bypass_1) begin
            read_data_1 = write_data;
         end else begin
            read_data_1 = regs_q[read_addr_1];
         end
         // A writeback landing this cycle resolves the pending hazard.
         busy_1 = busy_q[read_addr_1] & ~bypass_1;
      end
   end

   // Read port 2: same behaviour as port 1.
   always_comb begin
      read_data_2 = '0;
      busy_2      = 1'b0;
      if (rd_live_2) begin
         if (bypass_2) begin
            read_data_2 = write_data;
         end else begin
            read_data_2 = regs_q[read_addr_2];
         end
         busy_2 = busy_q[read_addr_2] & ~bypass_2;
      end
   end

   // Next busy vector: writeback clears first, then issue sets so set wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_hit) begin
         busy_d[write_addr] = 1'b0;
      end
      if (iss_hit) begin
         busy_d[issue_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Population count of the stored busy bits.
   always_comb begin
      busy_count = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_count = busy_count + (AW+1)'(busy_q[i]);
      end
   end

   // Data and busy state; reset discards any same-cycle write or issue.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         if (wr_hit) begin
            regs_q[write_addr] <= write_data;
         end
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 32-entry and a 24-entry instance share one stimulus stream.
// A behavioural array model predicts every output each cycle, and directed
// scenarios pin the model with literal expectations.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            reset;
   logic            write_enable;
   logic [AW-1:0]   write_addr;
   logic [XLEN-1:0] write_data;
   logic [AW-1:0]   read_addr_1;
   logic [AW-1:0]   read_addr_2;
   logic            issue_valid;
   logic [AW-1:0]   issue_addr;

   logic [XLEN-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic            b1_a, b2_a, b1_b, b2_b;
   logic [AW:0]     cnt_a, cnt_b;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREGS(32)) u_dut_32 (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr_1  (read_addr_1),
      .read_addr_2  (read_addr_2),
      .read_data_1  (rd1_a),
      .read_data_2  (rd2_a),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .busy_1       (b1_a),
      .busy_2       (b2_a),
      .busy_count   (cnt_a)
   );

   regfile_sb #(.XLEN(XLEN), .NREGS(24)) u_dut_24 (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr_1  (read_addr_1),
      .read_addr_2  (read_addr_2),
      .read_data_1  (rd1_b),
      .read_data_2  (rd2_b),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .busy_1       (b1_b),
      .busy_2       (b2_b),
      .busy_count   (cnt_b)
   );

   // Model state: index 0 is the 32-entry instance, index 1 the 24-entry one.
   logic [31:0] m_mem  [2][32];
   logic [31:0] m_busy [2];

   function automatic int nregs(input int k);
      return (k == 0) ? 32 : 24;
   endfunction

   function automatic bit live(input int k, input int a);
      return (a != 0) && (a < nregs(k));
   endfunction

   function automatic logic [31:0] exp_rd(input int k, input int a);
      if (!live(k, a)) return 32'h0;
      if (write_enable && int'(write_addr) == a) return write_data;
      return m_mem[k][a];
   endfunction

   function automatic bit exp_busy(input int k, input int a);
      if (!live(k, a)) return 1'b0;
      return m_busy[k][a] && !(write_enable && int'(write_addr) == a);
   endfunction

   function automatic int exp_cnt(input int k);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[k][i]);
      return n;
   endfunction

   // Model state update on each rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            for (int i = 0; i < 32; i++) m_mem[k][i] <= 32'h0;
            m_busy[k] <= 32'h0;
         end else begin
            if (write_enable && live(k, int'(write_addr))) begin
               m_mem[k][write_addr]  <= write_data;
               m_busy[k][write_addr] <= 1'b0;
            end
            if (issue_valid && live(k, int'(issue_addr))) begin
               m_busy[k][issue_addr] <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input string tag, input int k,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic b1, input logic b2, input logic [AW:0] cnt);
      chk({tag, ".rd1"},  64'(r1),  64'(exp_rd(k, int'(read_addr_1))));
      chk({tag, ".rd2"},  64'(r2),  64'(exp_rd(k, int'(read_addr_2))));
      chk({tag, ".busy1"}, 64'(b1), 64'(exp_busy(k, int'(read_addr_1))));
      chk({tag, ".busy2"}, 64'(b2), 64'(exp_busy(k, int'(read_addr_2))));
      chk({tag, ".cnt"},  64'(cnt), 64'(exp_cnt(k)));
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         compare_dut("n32", 0, rd1_a, rd2_a, b1_a, b2_a, cnt_a);
         compare_dut("n24", 1, rd1_b, rd2_b, b1_b, b2_b, cnt_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      write_enable = 1'b0;
      issue_valid  = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      write_enable = 1'b0;
      write_addr   = '0;
      write_data   = '0;
      read_addr_1  = '0;
      read_addr_2  = '0;
      issue_valid  = 1'b0;
      issue_addr   = '0;
      tick();
      tick();
      check_en = 1'b1;

      // Reset state.
      read_addr_1 = 5'd5;
      @(negedge clk);
      chk("reset_rd1", 64'(rd1_a), 64'h0);
      chk("reset_cnt", 64'(cnt_a), 64'h0);
      chk("reset_busy1", 64'(b1_a), 64'h0);
      tick();
      reset = 1'b0;

      // Write r5 then read it back; r0 stays zero.
      write_enable = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
      tick();
      write_enable = 1'b0; read_addr_1 = 5'd5;
      @(negedge clk);
      chk("r5_read", 64'(rd1_a), 64'hDEADBEEF);
      chk("r5_read_24", 64'(rd1_b), 64'hDEADBEEF);
      tick();
      write_enable = 1'b1; write_addr = 5'd0; write_data = 32'h1234; read_addr_1 = 5'd0;
      @(negedge clk);
      chk("r0_bypass", 64'(rd1_a), 64'h0);
      tick();
      write_enable = 1'b0;
      @(negedge clk);
      chk("r0_read", 64'(rd1_a), 64'h0);
      tick();

      // Same-cycle bypass on port 2 masks a pending busy.
      issue_valid = 1'b1; issue_addr = 5'd7;
      tick();
      issue_valid = 1'b0; read_addr_2 = 5'd7;
      @(negedge clk);
      chk("r7_busy", 64'(b2_a), 64'h1);
      tick();
      write_enable = 1'b1; write_addr = 5'd7; write_data = 32'hA5A5A5A5;
      @(negedge clk);
      chk("r7_bypass", 64'(rd2_a), 64'hA5A5A5A5);
      chk("r7_bypass_busy", 64'(b2_a), 64'h0);
      tick();
      write_enable = 1'b0;
      @(negedge clk);
      chk("r7_stored", 64'(rd2_a), 64'hA5A5A5A5);
      chk("r7_cnt", 64'(cnt_a), 64'h0);
      tick();

      // Issue r3, r9, r3 again, then write r3.
      issue_valid = 1'b1; issue_addr = 5'd3;
      tick();
      issue_addr = 5'd9;
      @(negedge clk);
      chk("cnt_after_r3", 64'(cnt_a), 64'd1);
      tick();
      issue_addr = 5'd3;
      @(negedge clk);
      chk("cnt_after_r9", 64'(cnt_a), 64'd2);
      tick();
      issue_valid = 1'b0;
      @(negedge clk);
      chk("cnt_after_r3_again", 64'(cnt_a), 64'd2);
      tick();
      write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h3333; read_addr_1 = 5'd3;
      read_addr_2 = 5'd9;
      @(negedge clk);
      chk("r3_wb_busy1", 64'(b1_a), 64'h0);
      chk("r9_busy2", 64'(b2_a), 64'h1);
      tick();
      write_enable = 1'b0;
      @(negedge clk);
      chk("cnt_after_wb3", 64'(cnt_a), 64'd1);
      chk("r3_busy1_after", 64'(b1_a), 64'h0);
      tick();

      // Issue and write r4 together: set wins, data still lands.
      issue_valid = 1'b1; issue_addr = 5'd4;
      write_enable = 1'b1; write_addr = 5'd4; write_data = 32'h55;
      tick();
      idle_inputs(); read_addr_1 = 5'd4;
      @(negedge clk);
      chk("r4_busy", 64'(b1_a), 64'h1);
      chk("r4_data", 64'(rd1_a), 64'h55);
      chk("r4_cnt", 64'(cnt_a), 64'd2);
      tick();

      // Fill r1..r31, mark r2/r6 busy, then reset against a write to r8.
      for (int i = 1; i < 32; i++) begin
         write_enable = 1'b1; write_addr = AW'(i); write_data = 32'h1000_0000 + 32'(i);
         tick();
      end
      write_enable = 1'b0;
      issue_valid = 1'b1; issue_addr = 5'd2;
      tick();
      issue_addr = 5'd6;
      tick();
      issue_valid = 1'b0; read_addr_1 = 5'd8;
      @(negedge clk);
      chk("fill_cnt", 64'(cnt_a), 64'd2);
      chk("fill_cnt_24", 64'(cnt_b), 64'd2);
      chk("fill_r8", 64'(rd1_a), 64'h1000_0008);
      tick();
      reset = 1'b1; write_enable = 1'b1; write_addr = 5'd8; write_data = 32'hFF;
      @(negedge clk);
      chk("reset_bypass_r8", 64'(rd1_a), 64'hFF);
      tick();
      reset = 1'b0; write_enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         read_addr_1 = AW'(i);
         read_addr_2 = AW'(i + 16);
         @(negedge clk);
         chk("post_reset_rd1", 64'(rd1_a), 64'h0);
         chk("post_reset_rd2", 64'(rd2_a), 64'h0);
         if (i == 2) chk("post_reset_busy_r2", 64'(b1_a), 64'h0);
         tick();
      end
      @(negedge clk);
      chk("post_reset_cnt", 64'(cnt_a), 64'h0);
      tick();

      // Out-of-range index 30 on the 24-entry instance.
      issue_valid = 1'b1; issue_addr = 5'd5;
      tick();
      issue_addr = 5'd30;
      write_enable = 1'b1; write_addr = 5'd30; write_data = 32'hCAFEF00D;
      read_addr_1 = 5'd30; read_addr_2 = 5'd30;
      @(negedge clk);
      chk("oor_rd1_24", 64'(rd1_b), 64'h0);
      chk("oor_busy2_24", 64'(b2_b), 64'h0);
      chk("oor_cnt_24", 64'(cnt_b), 64'd1);
      chk("r30_bypass_32", 64'(rd1_a), 64'hCAFEF00D);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("oor_rd1_24_after", 64'(rd1_b), 64'h0);
      chk("oor_cnt_24_after", 64'(cnt_b), 64'd1);
      chk("r30_cnt_32", 64'(cnt_a), 64'd2);
      chk("r30_busy_32", 64'(b1_a), 64'h1);
      tick();

      // Randomized traffic with biased address collisions.
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 99) == 0);
         write_enable = 1'($urandom_range(0, 1));
         write_addr   = AW'($urandom);
         write_data   = $urandom;
         issue_valid  = 1'($urandom_range(0, 1));
         issue_addr   = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom);
         read_addr_1  = ($urandom_range(0, 2) == 0) ? write_addr : AW'($urandom);
         read_addr_2  = ($urandom_range(0, 2) == 0) ? issue_addr : AW'($urandom);
         tick();
      end
      idle_inputs();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits, minimum 8.
REQ-002 SHALL have parameter NREGS, default 32: register count, 2..64; AW = clog2(NREGS) is a derived localparam.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port write_enable  input  1  writeback strobe.
REQ-006 SHALL have port write_addr  input  AW  writeback destination.
REQ-007 SHALL have port write_data  input  XLEN  writeback value.
REQ-008 SHALL have port read_addr_1  input  AW  source 1 index.
REQ-009 SHALL have port read_addr_2  input  AW  source 2 index.
REQ-010 SHALL have port read_data_1  output  XLEN  source 1 value, combinational.
REQ-011 SHALL have port read_data_2  output  XLEN  source 2 value, combinational.
REQ-012 SHALL have port issue_valid  input  1  instruction with destination issued this cycle.
REQ-013 SHALL have port issue_addr  input  AW  destination of the issued instruction.
REQ-014 SHALL have port busy_1  output  1  source 1 has a pending write, combinational.
REQ-015 SHALL have port busy_2  output  1  source 2 has a pending write, combinational.
REQ-016 SHALL have port busy_count  output  AW+1  number of set busy bits, combinational from state.

Function
REQ-017 SHALL hold NREGS data registers of XLEN bits and NREGS busy bits.
REQ-018 SHALL treat register 0 as hardwired zero: reads return 0, busy_n returns 0, and writes and issues to index 0 are ignored.
REQ-019 SHALL write write_data into write_addr on the rising edge when write_enable=1 and write_addr is nonzero and below NREGS.
REQ-020 SHALL drive read_data_n = write_data when write_enable=1 and write_addr==read_addr_n!=0 (same-cycle bypass); otherwise it SHALL drive the stored value.
REQ-021 SHALL return 0 on reads of indices >= NREGS and ignore writes and issues to them.
REQ-022 SHALL set busy[issue_addr] on the edge when issue_valid=1.
REQ-023 SHALL clear busy[write_addr] on the edge when write_enable=1.
REQ-024 SHALL let set win when issue and write target the same index in one cycle, so busy ends at 1 and data is still written.
REQ-025 SHALL leave busy at 1, with no nesting count, on an issue to an already-busy index.
REQ-026 SHALL accept a write to a non-busy index, store the data, and leave busy at 0.
REQ-027 SHALL drive busy_n = busy[read_addr_n] AND NOT (write_enable AND write_addr==read_addr_n), consistent with the bypass.
REQ-028 SHALL compute busy_count as the population count of the busy bits; maximum value NREGS-1.
REQ-029 SHALL have a total read/bypass/busy latency of 0 cycles; a write or issue takes effect in state 1 cycle later.

Reset
REQ-030 SHALL clear all data registers and busy bits on the rising edge where reset=1.
REQ-031 SHALL give reset priority over write_enable and issue_valid in the same cycle; both are discarded.
REQ-032 SHALL give these values during and after reset until the next write or issue: all read_data = 0 (bypass excepted), busy_1 = busy_2 = 0, busy_count = 0.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to r5, then read r5 on port 1 next cycle -> 0xDEADBEEF; read r0 after writing 0x1234 to r0 -> 0.
REQ-034 SHALL cover: write_enable=1, write_addr=7, write_data=0xA5A5A5A5 with read_addr_2=7 in the same cycle -> read_data_2=0xA5A5A5A5 and busy_2=0 combinationally.
REQ-035 SHALL cover: issue r3, then r9, then r3 again -> busy_count 1, 2, 2; write r3 -> busy_count 1 and busy_1=0 for r3.
REQ-036 SHALL cover: issue r4 and write r4 (0x55) in the same cycle -> next cycle busy[4]=1 and read r4=0x55.
REQ-037 SHALL cover: with r1..r31 written and r2,r6 busy, assert reset together with write r8=0xFF -> next cycle all reads 0, busy_count=0, r8=0.
REQ-038 SHALL cover: NREGS=24 build, write/issue/read at index 30 -> reads 0, busy unaffected, busy_count unchanged.
